stall_ctrl: RTL and testbench

Pipeline stall and hazard controller for the five-stage core. It sequences the register-file read path in ID against cases the ex/mem/wb bypass network cannot resolve: load-use hazards, multi-cycle divides in EX, and data-bus wait states in MEM. It emits the per-stage `stall` vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers. It also counts frozen-fetch cycles for performance monitoring.

---
 rtl/stall_ctrl.sv | 91 +++++++++
 tb/tb_stall_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// Stall/hazard controller: load-use, multi-cycle divide and MEM wait-state holds.
// Stall vector is combinational from state + ID/EX/MEM inputs; flush and reset mask everything.
module stall_ctrl #(
  parameter int DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_re1,
  input  logic [4:0]  id_raddr1,
  input  logic        id_re2,
  input  logic [4:0]  id_raddr2,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_is_load,
  input  logic        ex_div_start,
  input  logic        mem_stall_req,
  input  logic        flush,
  output logic [5:0]  stall,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] stall_cycles
);

  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

  typedef enum logic {
    RUN,
    DIV_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lu;
  logic          div_hold;
  logic          kill;

  assign lu = ex_wreg && ex_is_load && (ex_waddr != 5'd0) &&
              ((id_re1 && (id_raddr1 == ex_waddr)) ||
               (id_re2 && (id_raddr2 == ex_waddr)));

  assign div_hold = ((state == RUN) && ex_div_start) ||
                    ((state == DIV_WAIT) && (cnt != '0));

  // Reset and flush both squash every output in the cycle they are asserted.
  assign kill = rst || flush;

  always_comb begin
    stall = 6'b000000;
    if (!kill) begin
      if (lu)            stall = stall | 6'b000111;
      if (div_hold)      stall = stall | 6'b001111;
      if (mem_stall_req) stall = stall | 6'b011111;
    end
  end

  assign div_busy = !kill && (((state == RUN) && ex_div_start) || (state == DIV_WAIT));
  assign div_done = !kill && (state == DIV_WAIT) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= 32'd0;
    end else begin
      if (stall[0]) stall_cycles <= stall_cycles + 32'd1;
      if (flush) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        case (state)
          RUN: begin
            if (ex_div_start) begin
              state <= DIV_WAIT;
              cnt   <= CW'(DIV_LAT - 2);
            end
          end
          DIV_WAIT: begin
            // Counter keeps running under MEM wait states; EX holds the result.
            if (cnt == '0) state <= RUN;
            else           cnt   <= cnt - CW'(1);
          end
          default: begin
            state <= RUN;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl with DIV_LAT=33.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_re1, id_re2;
  logic [4:0]  id_raddr1, id_raddr2;
  logic        ex_wreg, ex_is_load, ex_div_start;
  logic [4:0]  ex_waddr;
  logic        mem_stall_req, flush;
  logic [5:0]  stall;
  logic        div_busy, div_done;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  stall_ctrl #(.DIV_LAT(33)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_re1       (id_re1),
    .id_raddr1    (id_raddr1),
    .id_re2       (id_re2),
    .id_raddr2    (id_raddr2),
    .ex_wreg      (ex_wreg),
    .ex_waddr     (ex_waddr),
    .ex_is_load   (ex_is_load),
    .ex_div_start (ex_div_start),
    .mem_stall_req(mem_stall_req),
    .flush        (flush),
    .stall        (stall),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_re1 = 0; id_raddr1 = 0; id_re2 = 0; id_raddr2 = 0;
    ex_wreg = 0; ex_waddr = 0; ex_is_load = 0; ex_div_start = 0;
    mem_stall_req = 0; flush = 0;
  endtask

  initial begin
    // Reset with inputs toggling.
    rst = 1;
    id_re1 = 1; id_raddr1 = 5'd3; id_re2 = 1; id_raddr2 = 5'd3;
    ex_wreg = 1; ex_waddr = 5'd3; ex_is_load = 1; ex_div_start = 1;
    mem_stall_req = 1; flush = 0;
    #1;
    chk("rst1_stall", 32'(stall), 32'h0);
    chk("rst1_busy", 32'(div_busy), 32'h0);
    chk("rst1_done", 32'(div_done), 32'h0);
    tick();
    ex_div_start = 0; mem_stall_req = 0; ex_is_load = 1; flush = 1;
    #1;
    chk("rst2_stall", 32'(stall), 32'h0);
    chk("rst2_busy", 32'(div_busy), 32'h0);
    tick();
    rst = 0;
    idle();
    #1;
    chk("rst_cycles", stall_cycles, 32'd0);
    chk("rst_idle_stall", 32'(stall), 32'h0);
    chk("rst_idle_busy", 32'(div_busy), 32'h0);

    // Load-use hazard on port 2.
    ex_is_load = 1; ex_wreg = 1; ex_waddr = 5'd5; id_re2 = 1; id_raddr2 = 5'd5;
    #1;
    chk("lu_stall", 32'(stall), 32'h07);
    chk("lu_busy", 32'(div_busy), 32'h0);
    tick();
    ex_is_load = 0; ex_wreg = 0; ex_waddr = 5'd0;  // bubble now in EX
    #1;
    chk("lu_release", 32'(stall), 32'h0);
    chk("lu_cycles", stall_cycles, 32'd1);
    ex_is_load = 1; ex_wreg = 1; ex_waddr = 5'd0; id_re2 = 1; id_raddr2 = 5'd0;
    #1;
    chk("lu_r0", 32'(stall), 32'h0);
    ex_waddr = 5'd5; id_raddr2 = 5'd5; id_re2 = 0;
    #1;
    chk("lu_no_re2", 32'(stall), 32'h0);
    id_re1 = 1; id_raddr1 = 5'd5;
    #1;
    chk("lu_port1", 32'(stall), 32'h07);
    ex_is_load = 0;
    #1;
    chk("lu_not_load", 32'(stall), 32'h0);
    idle();
    tick();

    // Plain divide: 32 stall cycles, done on cycle 33.
    for (int k = 1; k <= 34; k++) begin
      ex_div_start = (k == 1);
      #1;
      chk($sformatf("div_stall_c%0d", k), 32'(stall), (k <= 32) ? 32'h0F : 32'h0);
      chk($sformatf("div_done_c%0d", k), 32'(div_done), (k == 33) ? 32'h1 : 32'h0);
      chk($sformatf("div_busy_c%0d", k), 32'(div_busy), (k <= 33) ? 32'h1 : 32'h0);
      tick();
    end
    #1;
    chk("div_cycles", stall_cycles, 32'd33);

    // Divide with MEM wait on cycles 30..36.
    for (int k = 1; k <= 37; k++) begin
      ex_div_start  = (k == 1);
      mem_stall_req = (k >= 30 && k <= 36);
      #1;
      chk($sformatf("ovl_stall_c%0d", k), 32'(stall),
          (k >= 30 && k <= 36) ? 32'h1F : ((k <= 32) ? 32'h0F : 32'h0));
      chk($sformatf("ovl_done_c%0d", k), 32'(div_done), (k == 33) ? 32'h1 : 32'h0);
      tick();
    end
    idle();
    #1;
    chk("ovl_cycles", stall_cycles, 32'd69);

    // Flush on cycle 10 of a divide.
    for (int k = 1; k <= 40; k++) begin
      ex_div_start = (k == 1);
      flush        = (k == 10);
      #1;
      chk($sformatf("fl_stall_c%0d", k), 32'(stall), (k < 10) ? 32'h0F : 32'h0);
      chk($sformatf("fl_busy_c%0d", k), 32'(div_busy), (k < 10) ? 32'h1 : 32'h0);
      chk($sformatf("fl_done_c%0d", k), 32'(div_done), 32'h0);
      tick();
    end
    idle();
    #1;
    chk("fl_cycles", stall_cycles, 32'd78);

    // Start and flush together: divide never begins.
    ex_div_start = 1; flush = 1;
    #1;
    chk("sf_stall", 32'(stall), 32'h0);
    chk("sf_busy", 32'(div_busy), 32'h0);
    tick();
    idle();
    #1;
    chk("sf_next_busy", 32'(div_busy), 32'h0);
    chk("sf_next_stall", 32'(stall), 32'h0);
    tick();

    // Counter wrap through backdoor preload.
    dut.stall_cycles = 32'hFFFF_FFFE;
    mem_stall_req = 1;
    tick();
    tick();
    tick();
    mem_stall_req = 0;
    #1;
    chk("wrap_cycles", stall_cycles, 32'h0000_0001);

    // Flush does not clear the counter.
    flush = 1;
    tick();
    flush = 0;
    #1;
    chk("flush_keeps_cycles", stall_cycles, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
